// File: rtl/coax_tx_pkg.sv
// -----------------------------------------------------------------------------
// coax_tx_pkg
// Shared constants for the 3270 coax transmit path: word width, cells per
// framed word, code-violation length, frame state encodings and the helper
// that builds the 12-cell word pattern (sync, data MSB first, even parity).
// No ports (package).
// -----------------------------------------------------------------------------
package coax_tx_pkg;

    localparam int WORD_W         = 10;
    localparam int CELLS_PER_WORD = 12;
    // The violation is 3 half cells high followed by 3 half cells low.
    localparam int VIOL_HALVES    = 3;
    localparam int VIOL_CELLS     = VIOL_HALVES;
    // One '0' cell plus two cells of steady high.
    localparam int END_CELLS      = 3;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_QUIESCE = 3'd1;
    localparam logic [2:0] ST_VIOL    = 3'd2;
    localparam logic [2:0] ST_WORD    = 3'd3;
    localparam logic [2:0] ST_END     = 3'd4;

    // Sync '1', data bits MSB first, then a parity bit making the total
    // popcount of data+parity even. flip inverts the parity bit.
    function automatic logic [CELLS_PER_WORD-1:0] frame_word(
        input logic [WORD_W-1:0] w,
        input logic              flip
    );
        return {1'b1, w, (^w) ^ flip};
    endfunction

endpackage

// File: rtl/coax_tx_bit_timer.sv
// -----------------------------------------------------------------------------
// coax_tx_bit_timer
// Bit-cell timer for the coax transmitter. Counts 0..CLOCKS_PER_BIT-1 and
// wraps at the end of every cell.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-low
//   restart    in   holds the counter at 0 (start of a cell) while high
//   first_half out  counter is in the first half of the cell
//   mid_cell   out  last clock of the first half
//   end_cell   out  last clock of the cell
// -----------------------------------------------------------------------------
module coax_tx_bit_timer #(
    parameter int CLOCKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic first_half,
    output logic mid_cell,
    output logic end_cell
);

    localparam int HALF  = CLOCKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLOCKS_PER_BIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign first_half = (cnt_q < CNT_W'(HALF));
    assign mid_cell   = (cnt_q == CNT_W'(HALF - 1));
    assign end_cell   = (cnt_q == CNT_W'(CLOCKS_PER_BIT - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart || end_cell) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/coax_tx.sv
// -----------------------------------------------------------------------------
// coax_tx
// 3270 coax transmitter. Words enter through a one-word holding register and
// are sent as frames: quiesce cells of '1', a code violation, one or more
// 12-cell words (sync, data MSB first, even parity) and an end sequence.
// Each bit cell is bi-phase: ~b for the first half, b for the second half.
// Parameters:
//   CLOCKS_PER_BIT  clocks per bit cell (even, >= 4)
//   QUIESCE_BITS    '1' cells sent at frame start
// Ports:
//   clk               in   system clock
//   reset             in   synchronous, active-low
//   data[9:0]         in   word to send, bit 9 first
//   strobe            in   write data (taken when ready, or bypass at word end)
//   ready             out  holding register empty
//   tx                out  bi-phase line data (registered)
//   active            out  driver enable, high for the whole frame (registered)
//   force_bad_parity  in   only with COAX_TX_PARITY_INJECT_EN defined: inverts
//                          the parity of the word loading into the shifter
// Build option: COAX_TX_PARITY_INJECT_EN (undefined: parity always correct).
// -----------------------------------------------------------------------------
module coax_tx
    import coax_tx_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 16,
    parameter int QUIESCE_BITS   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] data,
    input  logic              strobe,
    output logic              ready,
    output logic              tx,
    output logic              active
`ifdef COAX_TX_PARITY_INJECT_EN
    ,
    input  logic              force_bad_parity
`endif
);

    localparam int IDX_MAX = (QUIESCE_BITS > CELLS_PER_WORD) ? QUIESCE_BITS : CELLS_PER_WORD;
    localparam int IDX_W   = $clog2(IDX_MAX);

    logic inject;
`ifdef COAX_TX_PARITY_INJECT_EN
    assign inject = force_bad_parity;
`else
    assign inject = 1'b0;
`endif

    logic [2:0]                state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [CELLS_PER_WORD-1:0] shift_q, shift_d;
    logic [WORD_W-1:0]         hold_q, hold_d;
    logic                      hold_vld_q, hold_vld_d;
    logic                      tx_q, tx_d;
    logic                      active_q, active_d;
    logic                      fh_d;

    logic first_half;
    logic mid_cell;
    logic end_cell;

    // The timer sits at the start of a cell while idle so the first quiesce
    // cell begins exactly on the clock after the frame starts.
    coax_tx_bit_timer #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .restart   (state_q == ST_IDLE),
        .first_half(first_half),
        .mid_cell  (mid_cell),
        .end_cell  (end_cell)
    );

    // Line level for a given state, cell index, current data bit and half.
    function automatic logic line_level(
        input logic [2:0]       st,
        input logic [IDX_W-1:0] idx,
        input logic             bit_v,
        input logic             fh
    );
        logic lvl;
        case (st)
            ST_QUIESCE: lvl = ~fh;
            ST_VIOL:    lvl = ((int'(idx) * 2 + (fh ? 0 : 1)) < VIOL_HALVES);
            ST_WORD:    lvl = fh ? ~bit_v : bit_v;
            ST_END:     lvl = (idx == '0) ? fh : 1'b1;
            default:    lvl = 1'b0;
        endcase
        return lvl;
    endfunction

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;

        // Writes only land in an empty holding register; others are dropped.
        if (strobe && !hold_vld_q) begin
            hold_d     = data;
            hold_vld_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                // hold_vld_q covers a word that was written during END.
                if (hold_vld_q || strobe) begin
                    state_d = ST_QUIESCE;
                    idx_d   = '0;
                end
            end
            ST_QUIESCE: begin
                if (end_cell) begin
                    if (idx_q == IDX_W'(QUIESCE_BITS - 1)) begin
                        state_d = ST_VIOL;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_VIOL: begin
                if (end_cell) begin
                    if (idx_q == IDX_W'(VIOL_CELLS - 1)) begin
                        state_d    = ST_WORD;
                        idx_d      = '0;
                        shift_d    = frame_word(hold_q, inject);
                        hold_vld_d = 1'b0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_WORD: begin
                if (end_cell) begin
                    if (idx_q == IDX_W'(CELLS_PER_WORD - 1)) begin
                        idx_d = '0;
                        if (hold_vld_q) begin
                            shift_d    = frame_word(hold_q, inject);
                            hold_vld_d = 1'b0;
                        end else if (strobe) begin
                            // Bypass: the word goes straight to the shifter and
                            // never occupies the holding register.
                            shift_d    = frame_word(data, inject);
                            hold_vld_d = 1'b0;
                        end else begin
                            state_d = ST_END;
                        end
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shift_d = {shift_q[CELLS_PER_WORD-2:0], 1'b0};
                    end
                end
            end
            ST_END: begin
                if (end_cell) begin
                    if (idx_q == IDX_W'(END_CELLS - 1)) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase

        // Half the timer will be in next clock, so tx/active can be registered
        // without adding latency.
        fh_d     = end_cell ? 1'b1 : (mid_cell ? 1'b0 : first_half);
        tx_d     = line_level(state_d, idx_d, shift_d[CELLS_PER_WORD-1], fh_d);
        active_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            hold_vld_q <= 1'b0;
            tx_q       <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hold_vld_q <= hold_vld_d;
            tx_q       <= tx_d;
            active_q   <= active_d;
        end
    end

    // Data-only registers; their contents are qualified by state/hold_vld.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        hold_q  <= hold_d;
    end

    assign ready  = ~hold_vld_q;
    assign tx     = tx_q;
    assign active = active_q;

endmodule
